dot_seq_ctrl: RTL and testbench
===============================

// Module: dot_seq_ctrl
// PURPOSE
//   Sequences the combinational s7.8 mult_sum_fixp datapath (DIM lanes) over vectors longer than DIM.
//   - Accepts one DIM-wide chunk of weights/inputs per handshake.
//   - Instantiates mult_sum_fixp once and accumulates the per-chunk partial sums in a wide accumulator.
//   - On the chunk flagged last, saturates the total to s7.8, applies optional ReLU and presents it on a valid/ready output.
//   - Sits between the weight/activation fetch logic and the neuron output buffer.
// PARAMETERS
//   DIM      2    lanes per chunk; passed to mult_sum_fixp dim
//   BITW     16   operand/result width; passed to mult_sum_fixp bitw
//   FRACW    8    fraction bits; passed to mult_sum_fixp fracw
//   ACCW     24   signed accumulator width, in the same s.FRACW scaling; ACCW > BITW
//   CNTW     8    chunk counter width; packet length limit is 2**CNTW chunks
// PORTS
//   clk        in   1          clock, rising edge
//   rst_n      in   1          asynchronous active-low reset
//   in_valid   in   1          chunk present on in_w/in_x/in_last/relu_en
//   in_ready   out  1          controller can accept a chunk
//   in_w       in   BITW x DIM weights for this chunk, s7.8 per lane
//   in_x       in   BITW x DIM inputs for this chunk, s7.8 per lane
//   in_last    in   1          this chunk ends the dot product
//   relu_en    in   1          ReLU select; sampled on the first chunk of a packet only
//   out_valid  out  1          result held on out_data
//   out_ready  in   1          downstream accepts the result
//   out_data   out  BITW       saturated (and optionally ReLU'd) s7.8 dot product
//   out_nchunk out  CNTW       chunks in the packet, minus 1
//   out_ovf    out  1          total fell outside the s7.8 range and was saturated
// BEHAVIOUR
//   Reset (async assert, sync release)
//     - State goes to ACC; accumulator, beat_cnt and the latched relu go to 0.
//     - out_valid=0, out_data=0, out_nchunk=0, out_ovf=0.
//   State ACC: in_ready=1, out_valid=0.
//     - A chunk is accepted on any edge where in_valid=1.
//     - Chunk sum p = mult_sum_fixp(in_w, in_x): BITW bits, truncated, wraps inside the datapath.
//     - Accumulate: acc <= acc + sext(p). The first chunk (beat_cnt==0) loads acc <= sext(p).
//     - First chunk also latches relu_en.
//     - beat_cnt increments per accepted chunk.
//     - beat_cnt reaching 2**CNTW-1 on a non-last chunk forces that chunk to be treated as last.
//     - Accepted chunk with in_last=1: register out_data, out_nchunk=beat_cnt and out_ovf; go to DONE.
//       out_valid rises the cycle after that edge (latency 1 from the last beat).
//   State DONE: in_ready=0, out_valid=1.
//     - out_data, out_nchunk and out_ovf stay stable until the handshake.
//     - in_valid is ignored.
//     - Edge with out_ready=1: return to ACC and clear acc and beat_cnt.
//       in_ready=1 the next cycle; no chunk is accepted on the handshake edge.
//   Arithmetic
//     - Accumulator addition wraps at ACCW bits; there is no internal saturation.
//     - Output saturation clamps the final acc to [-2**(BITW-1), 2**(BITW-1)-1] raw.
//       For s7.8: 0x8000 (-128.0) .. 0x7FFF (127.996). out_ovf=1 iff a clamp occurred.
//     - ReLU, when latched: a negative saturated result becomes 0x0000. out_ovf is unaffected.
//   Reset mid-packet: partial accumulation is discarded; no output is produced.
// TESTING
//   1. One chunk, w=[2.0,1.25], x=[5.0,4.0], last -> out_data=0x0F00 (15.0), nchunk=0, ovf=0, one cycle after accept.
//   2. Two chunks: test 1, then w=[1.0,0], x=[-3.0,0], last -> out_data=0x0C00 (12.0), nchunk=1.
//   3. ReLU: w=[1.0,0], x=[-3.0,0], last.
//      - relu_en=0 -> 0xFD00.
//      - relu_en=1 -> 0x0000.
//      - relu_en toggled on a later chunk has no effect.
//   4. Saturation: two chunks, each w=[8.0,8.0], x=[8.0,7.0] (0x7800 per chunk), 240.0 total -> 0x7FFF, ovf=1.
//      Negated x -> 0x8000, ovf=1.
//   5. Backpressure: hold out_ready=0 for 3 cycles with in_valid=1.
//      - out_data stays stable and in_ready=0.
//      - No chunk is consumed.
//      - After out_ready=1, the next packet's result is independent of the previous one.
//   6. Drop rst_n after the first chunk of a two-chunk packet.
//      - out_valid=0 immediately; after release in_ready=1.
//      - A fresh test-1 packet -> 0x0F00.

Source files
------------

// File: rtl/dot_seq_ctrl.sv
// dot_seq_ctrl: runs the combinational fixed-point dot-product datapath over
// vectors longer than DIM lanes. It takes one DIM-wide chunk per handshake and
// accumulates the chunk sums. On the last chunk it saturates the total to
// BITW bits, applies an optional ReLU, and holds the result on a valid/ready
// output.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   chunk handshake
//   in_w, in_x            DIM lanes of BITW-bit signed fixed point, lane i at [i*BITW +: BITW]
//   in_last               chunk ends the dot product
//   relu_en               ReLU select, sampled on the first chunk of a packet only
//   out_valid / out_ready result handshake
//   out_data              saturated (optionally ReLU'd) result
//   out_nchunk            chunks in the packet minus 1
//   out_ovf               the total was clamped to the output range

// mult_sum_fixp: sum over lanes of (w*x) >>> fracw. Each product is truncated,
// and the sum wraps at bitw bits.
module mult_sum_fixp #(
   parameter int unsigned dim   = 2,
   parameter int unsigned bitw  = 16,
   parameter int unsigned fracw = 8
) (
   input  logic [dim*bitw-1:0] w,
   input  logic [dim*bitw-1:0] x,
   output logic [bitw-1:0]     sum
);

   localparam int unsigned PRODW = 2 * bitw;

   logic signed [PRODW-1:0] wa;
   logic signed [PRODW-1:0] xa;
   logic signed [PRODW-1:0] prod;

   // Product per lane, scaled back to the operand fraction, summed with wrap
   always_comb begin
      sum  = '0;
      wa   = '0;
      xa   = '0;
      prod = '0;
      for (int i = 0; i < int'(dim); i++) begin
         wa   = PRODW'($signed(w[i*bitw +: bitw]));
         xa   = PRODW'($signed(x[i*bitw +: bitw]));
         prod = wa * xa;
         sum  = sum + bitw'(prod >>> fracw);
      end
   end

endmodule

module dot_seq_ctrl #(
   parameter int unsigned DIM   = 2,
   parameter int unsigned BITW  = 16,
   parameter int unsigned FRACW = 8,
   parameter int unsigned ACCW  = 24,
   parameter int unsigned CNTW  = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DIM*BITW-1:0] in_w,
   input  logic [DIM*BITW-1:0] in_x,
   input  logic                in_last,
   input  logic                relu_en,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BITW-1:0]     out_data,
   output logic [CNTW-1:0]     out_nchunk,
   output logic                out_ovf
);

   localparam logic [BITW-1:0]        OUT_MAX = {1'b0, {(BITW-1){1'b1}}};
   localparam logic [BITW-1:0]        OUT_MIN = {1'b1, {(BITW-1){1'b0}}};
   localparam logic signed [ACCW-1:0] ACC_MAX = ACCW'($signed(OUT_MAX));
   localparam logic signed [ACCW-1:0] ACC_MIN = ACCW'($signed(OUT_MIN));

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_DONE = 1'b1
   } state_t;

   state_t                 state;
   logic signed [ACCW-1:0] acc;
   logic [CNTW-1:0]        beat_cnt;
   logic                   relu_q;

   logic [BITW-1:0]        chunk_sum;
   logic signed [ACCW-1:0] chunk_ext;
   logic signed [ACCW-1:0] acc_sum;
   logic                   first;
   logic                   last_eff;
   logic                   relu_eff;
   logic [BITW-1:0]        sat_data;
   logic                   sat_ovf;
   logic [BITW-1:0]        res_data;

   mult_sum_fixp #(
      .dim   (DIM),
      .bitw  (BITW),
      .fracw (FRACW)
   ) u_mult_sum (
      .w   (in_w),
      .x   (in_x),
      .sum (chunk_sum)
   );

   // Next accumulator value, output clamp and ReLU for the chunk on the inputs
   always_comb begin
      chunk_ext = ACCW'($signed(chunk_sum));
      first     = (beat_cnt == '0);
      acc_sum   = first ? chunk_ext : acc + chunk_ext;
      // A full counter closes the packet so out_nchunk never wraps
      last_eff  = in_last || (&beat_cnt);
      relu_eff  = first ? relu_en : relu_q;
      sat_data  = BITW'(acc_sum);
      sat_ovf   = 1'b0;
      if (acc_sum > ACC_MAX) begin
         sat_data = OUT_MAX;
         sat_ovf  = 1'b1;
      end else if (acc_sum < ACC_MIN) begin
         sat_data = OUT_MIN;
         sat_ovf  = 1'b1;
      end
      res_data = (relu_eff && sat_data[BITW-1]) ? '0 : sat_data;
   end

   // Sequencer: accumulate chunks in ST_ACC, hold the result in ST_DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_ACC;
         acc        <= '0;
         beat_cnt   <= '0;
         relu_q     <= 1'b0;
         out_data   <= '0;
         out_nchunk <= '0;
         out_ovf    <= 1'b0;
      end else begin
         case (state)
            ST_ACC: begin
               if (in_valid) begin
                  acc      <= acc_sum;
                  beat_cnt <= beat_cnt + CNTW'(1);
                  if (first) begin
                     relu_q <= relu_en;
                  end
                  if (last_eff) begin
                     out_data   <= res_data;
                     out_nchunk <= beat_cnt;
                     out_ovf    <= sat_ovf;
                     state      <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  acc      <= '0;
                  beat_cnt <= '0;
                  state    <= ST_ACC;
               end
            end
            default: state <= ST_ACC;
         endcase
      end
   end

   // Handshake flags decode straight from the state register
   assign in_ready  = (state == ST_ACC);
   assign out_valid = (state == ST_DONE);

endmodule

// File: tb/tb_dot_seq_ctrl.sv
// tb_dot_seq_ctrl: directed bench for dot_seq_ctrl (DIM=2, s7.8). A fixed-point
// model computes each packet's expected result as its chunks are driven and
// pushes it to a scoreboard queue; the queue is popped when out_valid appears.
module tb_dot_seq_ctrl;

   localparam int unsigned DIM  = 2;
   localparam int unsigned BITW = 16;
   localparam int unsigned CNTW = 8;

   typedef struct packed {
      logic [BITW-1:0] data;
      logic [CNTW-1:0] nchunk;
      logic            ovf;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [DIM*BITW-1:0] in_w = '0;
   logic [DIM*BITW-1:0] in_x = '0;
   logic                in_last = 1'b0;
   logic                relu_en = 1'b0;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic [BITW-1:0]     out_data;
   logic [CNTW-1:0]     out_nchunk;
   logic                out_ovf;

   int checks = 0;
   int failures = 0;

   exp_t    sb_q[$];
   longint  m_acc = 0;
   int      m_cnt = 0;
   logic    m_relu = 1'b0;

   dot_seq_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_w       (in_w),
      .in_x       (in_x),
      .in_last    (in_last),
      .relu_en    (relu_en),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_nchunk (out_nchunk),
      .out_ovf    (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // s7.8 lane product, truncated toward minus infinity
   function automatic longint lane(input logic [15:0] w, input logic [15:0] x);
      longint p;
      p = longint'($signed(w)) * longint'($signed(x));
      return p >>> 8;
   endfunction

   // Drive one chunk, wait for acceptance, update the model
   task automatic send(input logic [15:0] w0, input logic [15:0] w1,
                       input logic [15:0] x0, input logic [15:0] x1,
                       input logic last, input logic relu);
      int   n;
      logic [15:0] csum;
      exp_t e;
      longint sat;
      in_w = {w1, w0};
      in_x = {x1, x0};
      in_last = last;
      relu_en = relu;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      csum = 16'(lane(w0, x0) + lane(w1, x1));
      if (m_cnt == 0) begin
         m_acc  = longint'($signed(csum));
         m_relu = relu;
      end else begin
         m_acc = m_acc + longint'($signed(csum));
      end
      if (last) begin
         e.ovf = 1'b0;
         sat = m_acc;
         if (sat > 32767)  begin sat = 32767;  e.ovf = 1'b1; end
         if (sat < -32768) begin sat = -32768; e.ovf = 1'b1; end
         if (m_relu && sat < 0) sat = 0;
         e.data   = 16'(sat);
         e.nchunk = 8'(m_cnt);
         sb_q.push_back(e);
         m_cnt = 0;
      end else begin
         m_cnt++;
      end
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (last) check("latency1_out_valid", 32'(out_valid), 32'd1);
   endtask

   // Wait for a result, compare against the scoreboard, then handshake
   task automatic collect(input string tag);
      int   n;
      exp_t e;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!out_valid) begin
         check({tag, "_timeout"}, 32'(out_valid), 32'd1);
      end else if (sb_q.size() == 0) begin
         check({tag, "_unexpected"}, 32'(sb_q.size()), 32'd1);
      end else begin
         e = sb_q.pop_front();
         check({tag, "_data"},   32'(out_data),   32'(e.data));
         check({tag, "_nchunk"}, 32'(out_nchunk), 32'(e.nchunk));
         check({tag, "_ovf"},    32'(out_ovf),    32'(e.ovf));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check({tag, "_post_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_post_in_ready"},  32'(in_ready),  32'd1);
   endtask

   initial begin
      logic [15:0] held;

      // Reset state
      #12;
      check("rst_out_valid",  32'(out_valid),  32'd0);
      check("rst_in_ready",   32'(in_ready),   32'd1);
      check("rst_out_data",   32'(out_data),   32'd0);
      check("rst_out_nchunk", 32'(out_nchunk), 32'd0);
      check("rst_out_ovf",    32'(out_ovf),    32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: single chunk, 2*5 + 1.25*4 = 15.0
      send(16'h0200, 16'h0140, 16'h0500, 16'h0400, 1'b1, 1'b0);
      check("t1_expect_model", 32'(sb_q[0].data), 32'h0F00);
      collect("t1");

      // 2: two chunks, 15.0 + (-3.0) = 12.0
      send(16'h0200, 16'h0140, 16'h0500, 16'h0400, 1'b0, 1'b0);
      send(16'h0100, 16'h0000, 16'hFD00, 16'h0000, 1'b1, 1'b0);
      collect("t2");

      // 3: ReLU off, on, and toggled on a later chunk
      send(16'h0100, 16'h0000, 16'hFD00, 16'h0000, 1'b1, 1'b0);
      collect("t3a");
      send(16'h0100, 16'h0000, 16'hFD00, 16'h0000, 1'b1, 1'b1);
      collect("t3b");
      send(16'h0100, 16'h0000, 16'h0100, 16'h0000, 1'b0, 1'b0);
      send(16'h0100, 16'h0000, 16'hFD00, 16'h0000, 1'b1, 1'b1);
      collect("t3c");

      // 4: positive and negative saturation
      send(16'h0800, 16'h0800, 16'h0800, 16'h0700, 1'b0, 1'b0);
      send(16'h0800, 16'h0800, 16'h0800, 16'h0700, 1'b1, 1'b0);
      collect("t4_pos");
      send(16'h0800, 16'h0800, 16'hF800, 16'hF900, 1'b0, 1'b0);
      send(16'h0800, 16'h0800, 16'hF800, 16'hF900, 1'b1, 1'b0);
      collect("t4_neg");

      // 5: backpressure with a chunk waiting on the input
      send(16'h0200, 16'h0140, 16'h0500, 16'h0400, 1'b1, 1'b0);
      held = 16'h0F00;
      in_w = {16'h7000, 16'h7000};
      in_x = {16'h7000, 16'h7000};
      in_last = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("t5_hold_data",     32'(out_data),  32'(held));
         check("t5_hold_in_ready", 32'(in_ready),  32'd0);
         check("t5_hold_valid",    32'(out_valid), 32'd1);
      end
      collect("t5");
      send(16'h0100, 16'h0000, 16'h0100, 16'h0000, 1'b1, 1'b0);
      collect("t5_next");

      // 6: reset in the middle of a two-chunk packet
      send(16'h0200, 16'h0140, 16'h0500, 16'h0400, 1'b0, 1'b0);
      rst_n = 1'b0;
      m_cnt = 0;
      #1;
      check("t6_rst_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("t6_in_ready", 32'(in_ready), 32'd1);
      send(16'h0200, 16'h0140, 16'h0500, 16'h0400, 1'b1, 1'b0);
      collect("t6");

      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
